// File: rtl/wb_arb_pkg.sv
// Shared definitions for the two-master Wishbone round-robin arbiter:
// FSM encoding, grant one-hot constants and watchdog sizing.
package wb_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUSY  = 2'd1,
    ST_ABORT = 2'd2
  } arb_state_e;

  localparam int unsigned TIMEOUT_DEFAULT = 255;

  localparam logic [1:0] GNT_NONE = 2'b00;
  localparam logic [1:0] GNT_M0   = 2'b01;
  localparam logic [1:0] GNT_M1   = 2'b10;

  function automatic int unsigned cnt_width(input int unsigned timeout);
    int unsigned w;
    w = 1;
    if (timeout > 0) w = $clog2(timeout + 1);
    return w;
  endfunction

endpackage

// File: rtl/wb_arb_watchdog.sv
// Saturating stall counter for the arbiter; flags expiry when a stalled
// strobe brings the count to TIMEOUT (TIMEOUT of 0 never expires).
module wb_arb_watchdog
  import wb_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic inc_i,
  output logic expire_o
);

  localparam int unsigned W = cnt_width(TIMEOUT);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)
      cnt_d = '0;
    else if (inc_i && (cnt_q != '1))
      cnt_d = cnt_q + W'(1);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  // Compared on the next value: a response in the reaching cycle clears
  // the count instead, so it always beats the abort.
  assign expire_o = (TIMEOUT != 0) && inc_i && (cnt_d == W'(TIMEOUT));

endmodule

// File: rtl/wb_rr_arbiter.sv
// Two-master Wishbone round-robin arbiter with a per-access watchdog that
// aborts stalled strobes with an err response to the owning master.
module wb_rr_arbiter
  import wb_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic [31:0] wbm0_adr_i,
  input  logic [31:0] wbm0_dat_i,
  input  logic [3:0]  wbm0_sel_i,
  input  logic        wbm0_we_i,
  input  logic        wbm0_cyc_i,
  input  logic        wbm0_stb_i,
  input  logic [2:0]  wbm0_cti_i,
  input  logic [1:0]  wbm0_bte_i,
  output logic [31:0] wbm0_dat_o,
  output logic        wbm0_ack_o,
  output logic        wbm0_err_o,
  output logic        wbm0_rty_o,
  input  logic [31:0] wbm1_adr_i,
  input  logic [31:0] wbm1_dat_i,
  input  logic [3:0]  wbm1_sel_i,
  input  logic        wbm1_we_i,
  input  logic        wbm1_cyc_i,
  input  logic        wbm1_stb_i,
  input  logic [2:0]  wbm1_cti_i,
  input  logic [1:0]  wbm1_bte_i,
  output logic [31:0] wbm1_dat_o,
  output logic        wbm1_ack_o,
  output logic        wbm1_err_o,
  output logic        wbm1_rty_o,
  output logic [31:0] wbs_adr_o,
  output logic [31:0] wbs_dat_o,
  output logic [3:0]  wbs_sel_o,
  output logic        wbs_we_o,
  output logic        wbs_cyc_o,
  output logic        wbs_stb_o,
  output logic [2:0]  wbs_cti_o,
  output logic [1:0]  wbs_bte_o,
  input  logic [31:0] wbs_dat_i,
  input  logic        wbs_ack_i,
  input  logic        wbs_err_i,
  input  logic        wbs_rty_i,
  output logic [1:0]  grant_o,
  output logic        timeout_o
);

  arb_state_e state_q;
  logic [1:0] grant_q, last_q;
  logic       timeout_q;
  logic       sel_m1, gnt_cyc, gnt_stb, busy, abort, slv_resp, expire;

  assign sel_m1   = grant_q[1];
  assign gnt_cyc  = sel_m1 ? wbm1_cyc_i : wbm0_cyc_i;
  assign gnt_stb  = sel_m1 ? wbm1_stb_i : wbm0_stb_i;
  assign busy     = (state_q == ST_BUSY);
  assign abort    = (state_q == ST_ABORT);
  assign slv_resp = wbs_ack_i | wbs_err_i | wbs_rty_i;

  wb_arb_watchdog #(.TIMEOUT(TIMEOUT)) u_wdog (
    .clk_i    (wb_clk_i),
    .rst_i    (wb_rst_i),
    .clr_i    (!busy || slv_resp),
    .inc_i    (busy && gnt_stb && !slv_resp),
    .expire_o (expire)
  );

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q   <= ST_IDLE;
      grant_q   <= GNT_NONE;
      last_q    <= GNT_M1;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (wbm0_cyc_i || wbm1_cyc_i) begin
            state_q <= ST_BUSY;
            if (wbm0_cyc_i && wbm1_cyc_i)
              grant_q <= (last_q == GNT_M0) ? GNT_M1 : GNT_M0;
            else
              grant_q <= wbm0_cyc_i ? GNT_M0 : GNT_M1;
          end
        end
        ST_BUSY: begin
          if (!gnt_cyc) begin
            state_q <= ST_IDLE;
            last_q  <= grant_q;
            grant_q <= GNT_NONE;
          end else if (expire) begin
            state_q   <= ST_ABORT;
            timeout_q <= 1'b1;
          end
        end
        ST_ABORT: begin
          if (!gnt_cyc) begin
            state_q <= ST_IDLE;
            last_q  <= grant_q;
            grant_q <= GNT_NONE;
          end else begin
            state_q <= ST_BUSY;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          grant_q <= GNT_NONE;
        end
      endcase
    end
  end

  always_comb begin
    wbs_adr_o  = '0;
    wbs_dat_o  = '0;
    wbs_sel_o  = '0;
    wbs_we_o   = 1'b0;
    wbs_cyc_o  = 1'b0;
    wbs_stb_o  = 1'b0;
    wbs_cti_o  = '0;
    wbs_bte_o  = '0;
    wbm0_dat_o = '0;
    wbm0_ack_o = 1'b0;
    wbm0_err_o = 1'b0;
    wbm0_rty_o = 1'b0;
    wbm1_dat_o = '0;
    wbm1_ack_o = 1'b0;
    wbm1_err_o = 1'b0;
    wbm1_rty_o = 1'b0;
    if (busy) begin
      wbs_adr_o = sel_m1 ? wbm1_adr_i : wbm0_adr_i;
      wbs_dat_o = sel_m1 ? wbm1_dat_i : wbm0_dat_i;
      wbs_sel_o = sel_m1 ? wbm1_sel_i : wbm0_sel_i;
      wbs_we_o  = sel_m1 ? wbm1_we_i  : wbm0_we_i;
      wbs_cyc_o = gnt_cyc;
      wbs_stb_o = gnt_stb;
      wbs_cti_o = sel_m1 ? wbm1_cti_i : wbm0_cti_i;
      wbs_bte_o = sel_m1 ? wbm1_bte_i : wbm0_bte_i;
      if (sel_m1) begin
        wbm1_dat_o = wbs_dat_i;
        wbm1_ack_o = wbs_ack_i;
        wbm1_err_o = wbs_err_i;
        wbm1_rty_o = wbs_rty_i;
      end else begin
        wbm0_dat_o = wbs_dat_i;
        wbm0_ack_o = wbs_ack_i;
        wbm0_err_o = wbs_err_i;
        wbm0_rty_o = wbs_rty_i;
      end
    end else if (abort) begin
      wbm0_err_o = !sel_m1;
      wbm1_err_o = sel_m1;
    end
  end

  assign grant_o   = grant_q;
  assign timeout_o = timeout_q;

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Bench for wb_rr_arbiter (TIMEOUT=8): table of per-cycle vectors plus
// hand-built watchdog and reset sequences, checked through a scoreboard queue.
module tb_wb_rr_arbiter;

  localparam logic [31:0] DK   = 32'hA5A5_0000;
  localparam logic        L    = 1'b0;
  localparam logic        H    = 1'b1;
  localparam logic [31:0] Z32  = 32'h0;
  localparam logic [2:0]  C0   = 3'b000;
  localparam logic [2:0]  CINC = 3'b010;
  localparam logic [2:0]  CEOB = 3'b111;
  localparam logic [1:0]  G0   = 2'b00;
  localparam logic [1:0]  GM0  = 2'b01;
  localparam logic [1:0]  GM1  = 2'b10;

  logic        clk, wb_rst_i;
  logic [31:0] wbm0_adr_i, wbm0_dat_i, wbm1_adr_i, wbm1_dat_i;
  logic [3:0]  wbm0_sel_i, wbm1_sel_i;
  logic        wbm0_we_i, wbm0_cyc_i, wbm0_stb_i, wbm1_we_i, wbm1_cyc_i, wbm1_stb_i;
  logic [2:0]  wbm0_cti_i, wbm1_cti_i;
  logic [1:0]  wbm0_bte_i, wbm1_bte_i;
  logic [31:0] wbm0_dat_o, wbm1_dat_o;
  logic        wbm0_ack_o, wbm0_err_o, wbm0_rty_o, wbm1_ack_o, wbm1_err_o, wbm1_rty_o;
  logic [31:0] wbs_adr_o, wbs_dat_o, wbs_dat_i;
  logic [3:0]  wbs_sel_o;
  logic        wbs_we_o, wbs_cyc_o, wbs_stb_o;
  logic [2:0]  wbs_cti_o;
  logic [1:0]  wbs_bte_o;
  logic        wbs_ack_i, wbs_err_i, wbs_rty_i;
  logic [1:0]  grant_o;
  logic        timeout_o;

  wb_rr_arbiter #(.TIMEOUT(8)) dut (
    .wb_clk_i(clk), .wb_rst_i(wb_rst_i),
    .wbm0_adr_i(wbm0_adr_i), .wbm0_dat_i(wbm0_dat_i), .wbm0_sel_i(wbm0_sel_i),
    .wbm0_we_i(wbm0_we_i), .wbm0_cyc_i(wbm0_cyc_i), .wbm0_stb_i(wbm0_stb_i),
    .wbm0_cti_i(wbm0_cti_i), .wbm0_bte_i(wbm0_bte_i),
    .wbm0_dat_o(wbm0_dat_o), .wbm0_ack_o(wbm0_ack_o), .wbm0_err_o(wbm0_err_o), .wbm0_rty_o(wbm0_rty_o),
    .wbm1_adr_i(wbm1_adr_i), .wbm1_dat_i(wbm1_dat_i), .wbm1_sel_i(wbm1_sel_i),
    .wbm1_we_i(wbm1_we_i), .wbm1_cyc_i(wbm1_cyc_i), .wbm1_stb_i(wbm1_stb_i),
    .wbm1_cti_i(wbm1_cti_i), .wbm1_bte_i(wbm1_bte_i),
    .wbm1_dat_o(wbm1_dat_o), .wbm1_ack_o(wbm1_ack_o), .wbm1_err_o(wbm1_err_o), .wbm1_rty_o(wbm1_rty_o),
    .wbs_adr_o(wbs_adr_o), .wbs_dat_o(wbs_dat_o), .wbs_sel_o(wbs_sel_o), .wbs_we_o(wbs_we_o),
    .wbs_cyc_o(wbs_cyc_o), .wbs_stb_o(wbs_stb_o), .wbs_cti_o(wbs_cti_o), .wbs_bte_o(wbs_bte_o),
    .wbs_dat_i(wbs_dat_i), .wbs_ack_i(wbs_ack_i), .wbs_err_i(wbs_err_i), .wbs_rty_i(wbs_rty_i),
    .grant_o(grant_o), .timeout_o(timeout_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        c0;
    logic [31:0] a0;
    logic [2:0]  t0;
    logic        c1;
    logic [31:0] a1;
    logic        ack;
    logic [31:0] sd;
  } in_t;

  typedef struct packed {
    logic [1:0]  gnt;
    logic        scyc, sstb, swe;
    logic [31:0] sadr, sdat;
    logic [3:0]  ssel;
    logic [2:0]  scti;
    logic [1:0]  sbte;
    logic        m0ack, m0err, m0rty;
    logic [31:0] m0dat;
    logic        m1ack, m1err, m1rty;
    logic [31:0] m1dat;
    logic        tmo;
  } out_t;

  typedef struct {
    logic  r;
    string nm;
    in_t   i;
    out_t  e;
  } vec_t;

  typedef struct {
    string nm;
    out_t  e;
  } sb_t;

  vec_t tbl[$];
  sb_t  sb_q[$];
  int   n_vec = 0;
  int   n_err = 0;
  out_t zo;

  function automatic in_t vi(input logic c0, input logic [31:0] a0, input logic [2:0] t0,
                             input logic c1, input logic [31:0] a1,
                             input logic ack, input logic [31:0] sd);
    in_t i;
    i.c0 = c0; i.a0 = a0; i.t0 = t0; i.c1 = c1; i.a1 = a1; i.ack = ack; i.sd = sd;
    return i;
  endfunction

  // Side-band slave fields follow from the bench's own drive rule:
  // dat = adr^DK, we/sel/bte all ones while a master holds cyc.
  function automatic out_t vo(input logic [1:0] g, input logic s, input logic [31:0] a,
                              input logic [2:0] t, input logic k0, input logic e0,
                              input logic [31:0] d0, input logic k1, input logic [31:0] d1,
                              input logic tmo);
    out_t o;
    o = '0;
    o.gnt = g; o.scyc = s; o.sstb = s; o.sadr = a; o.scti = t;
    o.m0ack = k0; o.m0err = e0; o.m0dat = d0;
    o.m1ack = k1; o.m1dat = d1; o.tmo = tmo;
    o.swe  = s;
    o.ssel = {4{s}};
    o.sbte = {2{s}};
    o.sdat = s ? (a ^ DK) : Z32;
    return o;
  endfunction

  function automatic out_t sample();
    out_t o;
    o.gnt = grant_o; o.scyc = wbs_cyc_o; o.sstb = wbs_stb_o; o.swe = wbs_we_o;
    o.sadr = wbs_adr_o; o.sdat = wbs_dat_o; o.ssel = wbs_sel_o; o.scti = wbs_cti_o;
    o.sbte = wbs_bte_o;
    o.m0ack = wbm0_ack_o; o.m0err = wbm0_err_o; o.m0rty = wbm0_rty_o; o.m0dat = wbm0_dat_o;
    o.m1ack = wbm1_ack_o; o.m1err = wbm1_err_o; o.m1rty = wbm1_rty_o; o.m1dat = wbm1_dat_o;
    o.tmo = timeout_o;
    return o;
  endfunction

  task automatic drive(input in_t i);
    wbm0_cyc_i = i.c0; wbm0_stb_i = i.c0; wbm0_adr_i = i.a0; wbm0_cti_i = i.t0;
    wbm0_dat_i = i.c0 ? (i.a0 ^ DK) : Z32;
    wbm0_we_i = i.c0; wbm0_sel_i = {4{i.c0}}; wbm0_bte_i = {2{i.c0}};
    wbm1_cyc_i = i.c1; wbm1_stb_i = i.c1; wbm1_adr_i = i.a1; wbm1_cti_i = C0;
    wbm1_dat_i = i.c1 ? (i.a1 ^ DK) : Z32;
    wbm1_we_i = i.c1; wbm1_sel_i = {4{i.c1}}; wbm1_bte_i = {2{i.c1}};
    wbs_ack_i = i.ack; wbs_dat_i = i.sd; wbs_err_i = L; wbs_rty_i = L;
  endtask

  task automatic push_exp(input string nm, input out_t e);
    sb_t s;
    s.nm = nm; s.e = e;
    sb_q.push_back(s);
  endtask

  task automatic check_out();
    sb_t  s;
    out_t act;
    n_vec++;
    if (sb_q.size() == 0) begin
      n_err++;
      $display("FAIL scoreboard: output sampled with no expectation queued");
    end else begin
      s   = sb_q.pop_front();
      act = sample();
      if (act !== s.e) begin
        n_err++;
        $display("FAIL %s: got %h, expected %h", s.nm, act, s.e);
      end
    end
  endtask

  task automatic apply(input string nm, input in_t i, input out_t e);
    drive(i);
    push_exp(nm, e);
    @(negedge clk);
    check_out();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive(vi(L, Z32, C0, L, Z32, L, Z32));
    wb_rst_i = H;
    @(posedge clk);
    #1;
    push_exp("reset", zo);
    check_out();
    @(posedge clk);
    #1;
    wb_rst_i = L;
  endtask

  task automatic add(input logic r, input string nm, input in_t i, input out_t e);
    vec_t v;
    v.r = r; v.nm = nm; v.i = i; v.e = e;
    tbl.push_back(v);
  endtask

  initial begin
    #200000;
    $display("FAIL global-timeout: bench still running at %0t, required finish earlier", $time);
    $fatal(1);
  end

  initial begin
    in_t  ii;
    out_t busy0;
    wb_rst_i = H;
    zo = vo(G0, L, Z32, C0, L, L, Z32, L, Z32, L);

    // Single master, slave acks on its 2nd strobed cycle
    add(H, "A.idle",   vi(L, Z32, C0, L, Z32, L, Z32), zo);
    add(L, "A.req",    vi(H, 32'h1000, C0, L, Z32, L, Z32), zo);
    add(L, "A.grant",  vi(H, 32'h1000, C0, L, Z32, L, Z32), vo(GM0, H, 32'h1000, C0, L, L, Z32, L, Z32, L));
    add(L, "A.ack",    vi(H, 32'h1000, C0, L, Z32, H, 32'hDEADBEEF), vo(GM0, H, 32'h1000, C0, H, L, 32'hDEADBEEF, L, Z32, L));
    add(L, "A.drop",   vi(L, Z32, C0, L, Z32, L, Z32), vo(GM0, L, Z32, C0, L, L, Z32, L, Z32, L));
    add(L, "A.rel",    vi(L, Z32, C0, L, Z32, L, Z32), zo);
    // Tie after reset, then alternation
    add(H, "B.tie",    vi(H, 32'hA000, C0, H, 32'hB000, L, Z32), zo);
    add(L, "B.g0",     vi(H, 32'hA000, C0, H, 32'hB000, L, Z32), vo(GM0, H, 32'hA000, C0, L, L, Z32, L, Z32, L));
    add(L, "B.ack0",   vi(H, 32'hA000, C0, H, 32'hB000, H, 32'h11), vo(GM0, H, 32'hA000, C0, H, L, 32'h11, L, Z32, L));
    add(L, "B.drop0",  vi(L, Z32, C0, H, 32'hB000, L, Z32), vo(GM0, L, Z32, C0, L, L, Z32, L, Z32, L));
    add(L, "B.idle1",  vi(L, Z32, C0, H, 32'hB000, L, Z32), zo);
    add(L, "B.g1",     vi(L, Z32, C0, H, 32'hB000, L, Z32), vo(GM1, H, 32'hB000, C0, L, L, Z32, L, Z32, L));
    add(L, "B.ack1",   vi(L, Z32, C0, H, 32'hB000, H, 32'h22), vo(GM1, H, 32'hB000, C0, L, L, Z32, H, 32'h22, L));
    add(L, "B.wait0",  vi(H, 32'hA100, C0, H, 32'hB000, L, Z32), vo(GM1, H, 32'hB000, C0, L, L, Z32, L, Z32, L));
    add(L, "B.drop1",  vi(H, 32'hA100, C0, L, Z32, L, Z32), vo(GM1, L, Z32, C0, L, L, Z32, L, Z32, L));
    add(L, "B.idle2",  vi(H, 32'hA100, C0, L, Z32, L, Z32), zo);
    add(L, "B.g0b",    vi(H, 32'hA100, C0, L, Z32, L, Z32), vo(GM0, H, 32'hA100, C0, L, L, Z32, L, Z32, L));
    add(L, "B.ack0b",  vi(H, 32'hA100, C0, L, Z32, H, 32'h33), vo(GM0, H, 32'hA100, C0, H, L, 32'h33, L, Z32, L));
    add(L, "B.drop0b", vi(L, Z32, C0, L, Z32, L, Z32), vo(GM0, L, Z32, C0, L, L, Z32, L, Z32, L));
    add(L, "B.rel",    vi(L, Z32, C0, L, Z32, L, Z32), zo);
    // m0 4-beat incrementing burst with m1 waiting
    add(L, "C.req",    vi(H, 32'h200, CINC, L, Z32, L, Z32), zo);
    add(L, "C.g0",     vi(H, 32'h200, CINC, H, 32'h900, L, Z32), vo(GM0, H, 32'h200, CINC, L, L, Z32, L, Z32, L));
    add(L, "C.beat0",  vi(H, 32'h200, CINC, H, 32'h900, H, 32'hB0), vo(GM0, H, 32'h200, CINC, H, L, 32'hB0, L, Z32, L));
    add(L, "C.beat1",  vi(H, 32'h204, CINC, H, 32'h900, H, 32'hB1), vo(GM0, H, 32'h204, CINC, H, L, 32'hB1, L, Z32, L));
    add(L, "C.beat2",  vi(H, 32'h208, CINC, H, 32'h900, H, 32'hB2), vo(GM0, H, 32'h208, CINC, H, L, 32'hB2, L, Z32, L));
    add(L, "C.beat3",  vi(H, 32'h20C, CEOB, H, 32'h900, H, 32'hB3), vo(GM0, H, 32'h20C, CEOB, H, L, 32'hB3, L, Z32, L));
    add(L, "C.drop0",  vi(L, Z32, C0, H, 32'h900, L, Z32), vo(GM0, L, Z32, C0, L, L, Z32, L, Z32, L));
    add(L, "C.idle",   vi(L, Z32, C0, H, 32'h900, L, Z32), zo);
    add(L, "C.g1",     vi(L, Z32, C0, H, 32'h900, L, Z32), vo(GM1, H, 32'h900, C0, L, L, Z32, L, Z32, L));
    add(L, "C.ack1",   vi(L, Z32, C0, H, 32'h900, H, 32'hC9), vo(GM1, H, 32'h900, C0, L, L, Z32, H, 32'hC9, L));
    add(L, "C.drop1",  vi(L, Z32, C0, L, Z32, L, Z32), vo(GM1, L, Z32, C0, L, L, Z32, L, Z32, L));
    add(L, "C.rel",    vi(L, Z32, C0, L, Z32, L, Z32), zo);

    for (int k = 0; k < tbl.size(); k++) begin
      if (tbl[k].r) do_reset();
      apply(tbl[k].nm, tbl[k].i, tbl[k].e);
    end

    // Watchdog: 8 stalled strobes, then one ABORT cycle; second abort with cyc dropped
    ii    = vi(H, 32'h300, C0, L, Z32, L, Z32);
    busy0 = vo(GM0, H, 32'h300, C0, L, L, Z32, L, Z32, L);
    apply("D.req", ii, zo);
    for (int k = 1; k <= 8; k++) apply($sformatf("D.stall%0d", k), ii, busy0);
    apply("D.abort", ii, vo(GM0, L, Z32, C0, L, H, Z32, L, Z32, H));
    for (int k = 1; k <= 8; k++) apply($sformatf("D.restall%0d", k), ii, busy0);
    apply("D.abort2", vi(L, Z32, C0, L, Z32, L, Z32), vo(GM0, L, Z32, C0, L, H, Z32, L, Z32, H));
    apply("D.idle", vi(L, Z32, C0, L, Z32, L, Z32), zo);
    apply("D.stayidle", vi(L, Z32, C0, L, Z32, L, Z32), zo);

    // Ack on the stall that would bring the count to 8 beats the abort
    ii    = vi(H, 32'h400, C0, L, Z32, L, Z32);
    busy0 = vo(GM0, H, 32'h400, C0, L, L, Z32, L, Z32, L);
    apply("E.req", ii, zo);
    for (int k = 1; k <= 7; k++) apply($sformatf("E.stall%0d", k), ii, busy0);
    apply("E.ack", vi(H, 32'h400, C0, L, Z32, H, 32'hCAFE), vo(GM0, H, 32'h400, C0, H, L, 32'hCAFE, L, Z32, L));
    apply("E.noabort", ii, busy0);
    apply("E.noabort2", ii, busy0);
    apply("E.drop", vi(L, Z32, C0, L, Z32, L, Z32), vo(GM0, L, Z32, C0, L, L, Z32, L, Z32, L));
    apply("E.rel", vi(L, Z32, C0, L, Z32, L, Z32), zo);

    // Asynchronous reset mid-access; last_grant was m0 so the tie proves it reset to m1
    ii = vi(H, 32'h500, C0, L, Z32, L, Z32);
    apply("F.req", ii, zo);
    apply("F.busy", ii, vo(GM0, H, 32'h500, C0, L, L, Z32, L, Z32, L));
    drive(vi(H, 32'h500, C0, L, Z32, H, 32'h77));
    #2;
    wb_rst_i = H;
    #1;
    push_exp("F.async_rst", zo);
    check_out();
    @(posedge clk);
    #1;
    wb_rst_i = L;
    ii = vi(H, 32'h600, C0, H, 32'h700, L, Z32);
    apply("F.tie", ii, zo);
    apply("F.g0", ii, vo(GM0, H, 32'h600, C0, L, L, Z32, L, Z32, L));
    apply("F.drop", vi(L, Z32, C0, L, Z32, L, Z32), vo(GM0, L, Z32, C0, L, L, Z32, L, Z32, L));
    apply("F.rel", vi(L, Z32, C0, L, Z32, L, Z32), zo);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
